// File: rtl/handshake_tx_synchronizer.sv
// handshake_tx_synchronizer: source side of a 4-phase REQ/ACK crossing for a multi-bit bus.
// RX_ACK is brought in through a NUM_STAGES flop chain; TX_REQ, TX_DATA and DONE are registered.
module handshake_tx_synchronizer #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] IN_DATA,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [BUS_WIDTH-1:0] TX_DATA,
  output logic                 TX_REQ,
  input  logic                 RX_ACK,
  output logic                 DONE
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE} state_t;
  state_t                state, state_nxt;
  logic [NUM_STAGES-1:0] ack_sync;
  logic                  ack_s;
  logic                  accept;
  logic [BUS_WIDTH-1:0]  data_nxt;
  logic                  req_nxt;
  logic                  done_nxt;
  assign ack_s    = ack_sync[NUM_STAGES-1];
  // a stale ACK left over from the far side must fall before a new word is launched
  assign IN_READY = !RST && state == S_IDLE && !ack_s;
  assign accept   = IN_VALID && IN_READY;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      ack_sync <= '0;
      TX_DATA  <= '0;
      TX_REQ   <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ack_sync <= {ack_sync[NUM_STAGES-2:0], RX_ACK};
      TX_DATA  <= data_nxt;
      TX_REQ   <= req_nxt;
      DONE     <= done_nxt;
    end
  end
  always_comb begin
    state_nxt = state == S_IDLE ? (accept ? S_REQ : S_IDLE) :
                state == S_REQ  ? (ack_s ? S_RELEASE : S_REQ) :
                                  (ack_s ? S_RELEASE : S_IDLE);
  end
  always_comb begin
    data_nxt = (state == S_IDLE && accept) ? IN_DATA : TX_DATA;
    req_nxt  = state == S_IDLE ? accept : state == S_REQ ? !ack_s : 1'b0;
    done_nxt = state == S_RELEASE && !ack_s;
  end
endmodule

// File: tb/tb_handshake_tx_synchronizer.sv
// tb_handshake_tx_synchronizer: directed stimulus with a queue scoreboard; a far-side model
// echoes TX_REQ onto RX_ACK three clocks later and a monitor checks every launched word.
module tb_handshake_tx_synchronizer;
  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] TX_DATA;
  logic       TX_REQ;
  logic       RX_ACK;
  logic       DONE;
  logic       far_en, ack_man;
  logic [2:0] pipe = '0;
  logic [1:0] tb_sync;
  logic [7:0] sb[$];
  int         total = 0, bad = 0, done_cnt = 0;
  logic       prev_req = 1'b0, prev_done = 1'b0, prev_acks = 1'b0;
  logic [7:0] prev_data = '0;

  handshake_tx_synchronizer #(.BUS_WIDTH(8), .NUM_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .TX_DATA(TX_DATA), .TX_REQ(TX_REQ), .RX_ACK(RX_ACK), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) pipe <= {pipe[1:0], TX_REQ};
  assign RX_ACK = far_en ? pipe[2] : ack_man;

  always @(posedge CLK or posedge RST)
    if (RST) tb_sync <= '0;
    else tb_sync <= {tb_sync[0], RX_ACK};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (TX_REQ && !prev_req) begin
      if (sb.size() == 0) chk("unexpected_transfer", {24'h0, TX_DATA}, 32'hFFFF_FFFF);
      else chk("far_capture", {24'h0, TX_DATA}, {24'h0, sb.pop_front()});
      chk("req_rise_with_ack_s", {31'h0, prev_acks}, 0);
    end
    if (TX_REQ && prev_req) chk("data_stable", {24'h0, TX_DATA}, {24'h0, prev_data});
    if (DONE) begin
      done_cnt++;
      chk("done_one_cycle", {31'h0, prev_done}, 0);
    end
    prev_req  = TX_REQ;
    prev_data = TX_DATA;
    prev_done = DONE;
    prev_acks = tb_sync[1];
  end

  initial begin
    int n, fall, dn, d0, idx;
    logic acc;
    RST = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'h5A; far_en = 1'b1; ack_man = 1'b0;
    // 1: reset state
    repeat (3) @(negedge CLK);
    chk("rst_tx_req", {31'h0, TX_REQ}, 0);
    chk("rst_tx_data", {24'h0, TX_DATA}, 0);
    chk("rst_done", {31'h0, DONE}, 0);
    chk("rst_in_ready", {31'h0, IN_READY}, 0);
    IN_VALID = 1'b0;
    RST = 1'b0;
    #1 chk("ready_after_rst", {31'h0, IN_READY}, 1);
    @(negedge CLK);
    // 2/3: single word with hold-off traffic during REQ
    d0 = done_cnt;
    IN_DATA = 8'hA5; IN_VALID = 1'b1; sb.push_back(8'hA5);
    chk("ready_before_a5", {31'h0, IN_READY}, 1);
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("a5_tx_data", {24'h0, TX_DATA}, 32'hA5);
    chk("a5_tx_req", {31'h0, TX_REQ}, 1);
    n = 0; fall = -1; dn = -1;
    while (dn < 0 && n < 40) begin
      @(negedge CLK);
      n++;
      if (n == 1) begin IN_DATA = 8'h11; IN_VALID = 1'b1; end
      if (n == 2 || n == 3) begin
        chk("holdoff_ready", {31'h0, IN_READY}, 0);
        chk("holdoff_data", {24'h0, TX_DATA}, 32'hA5);
        IN_DATA = 8'h22;
        if (n == 3) IN_VALID = 1'b0;
      end
      if (!TX_REQ && fall < 0) fall = n;
      if (DONE && dn < 0) begin
        dn = n;
        chk("ready_in_done_cycle", {31'h0, IN_READY}, 1);
      end
    end
    chk("req_fall_edge", fall, 6);
    chk("done_edge", dn, 12);
    @(negedge CLK);
    chk("done_cleared", {31'h0, DONE}, 0);
    repeat (5) @(negedge CLK);
    chk("single_done_count", done_cnt - d0, 1);
    // 4: streaming with IN_VALID held
    d0 = done_cnt;
    sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h03);
    IN_DATA = 8'h01; IN_VALID = 1'b1; idx = 0;
    for (int k = 0; k < 200 && idx < 3; k++) begin
      acc = IN_READY;
      @(negedge CLK);
      if (acc) begin
        idx++;
        IN_DATA = 8'(idx + 1);
      end
    end
    IN_VALID = 1'b0;
    chk("stream_accepts", idx, 3);
    for (int k = 0; k < 100 && done_cnt - d0 < 3; k++) @(negedge CLK);
    repeat (5) @(negedge CLK);
    chk("stream_done_count", done_cnt - d0, 3);
    chk("stream_queue_empty", sb.size(), 0);
    // 5: reset mid-transfer with ACK still high
    sb.push_back(8'h77);
    IN_DATA = 8'h77; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    for (int k = 0; k < 20 && !RX_ACK; k++) @(negedge CLK);
    chk("midop_req_before_rst", {31'h0, TX_REQ}, 1);
    chk("midop_ack_before_rst", {31'h0, RX_ACK}, 1);
    d0 = done_cnt;
    far_en = 1'b0; ack_man = 1'b1;
    RST = 1'b1;
    #1;
    chk("midop_req_drop", {31'h0, TX_REQ}, 0);
    chk("midop_data_clear", {24'h0, TX_DATA}, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      chk("midop_stale_ack_block", {31'h0, IN_READY}, 0);
      @(negedge CLK);
    end
    ack_man = 1'b0;
    @(negedge CLK);
    chk("midop_ready_1edge", {31'h0, IN_READY}, 0);
    @(negedge CLK);
    chk("midop_ready_2edge", {31'h0, IN_READY}, 1);
    chk("midop_no_done", done_cnt - d0, 0);
    repeat (4) @(negedge CLK);
    far_en = 1'b1;
    // 6: spurious ACK pulse in IDLE
    d0 = done_cnt;
    far_en = 1'b0; ack_man = 1'b1;
    for (int m = 1; m <= 9; m++) begin
      @(negedge CLK);
      if (m == 5) ack_man = 1'b0;
      chk("spur_ready", {31'h0, IN_READY}, (m >= 2 && m <= 6) ? 0 : 1);
      chk("spur_req", {31'h0, TX_REQ}, 0);
    end
    chk("spur_no_done", done_cnt - d0, 0);
    far_en = 1'b1;
    repeat (4) @(negedge CLK);
    chk("final_queue_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
